// File: rtl/bcd_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl_if
//   Bundles the signals between the front panel / BCD counter side and the
//   measurement-sequencing controller.
//
//   start, stop, clear : single-cycle command pulses (debounced front panel)
//   bcd_in             : live BCD counter value, digit 0 in bits [3:0]
//   cnt_en, cnt_clr    : registered enable / synchronous clear to the counter
//   bcd_latched        : value captured at the end of a measurement
//   valid              : bcd_latched holds a completed measurement
//   overflow           : counter wrapped past all-nines in this measurement
//   running            : measurement in progress
//
//   master : front panel / counter / display side
//   slave  : the controller
// -----------------------------------------------------------------------------
interface bcd_count_ctrl_if #(
    parameter int N = 3
);
    logic           start;
    logic           stop;
    logic           clear;
    logic [4*N-1:0] bcd_in;
    logic           cnt_en;
    logic           cnt_clr;
    logic [4*N-1:0] bcd_latched;
    logic           valid;
    logic           overflow;
    logic           running;

    modport master (
        output start, stop, clear, bcd_in,
        input  cnt_en, cnt_clr, bcd_latched, valid, overflow, running
    );

    modport slave (
        input  start, stop, clear, bcd_in,
        output cnt_en, cnt_clr, bcd_latched, valid, overflow, running
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl
//   Measurement sequencer for an N-digit BCD counter. A prescaler produces one
//   count-enable tick every PRESCALE clocks while running; the measurement ends
//   on a stop pulse or after GATE_TICKS ticks (0 = free-run), the final BCD
//   value is latched and a sticky overflow flag records any wrap past
//   all-nines. A clear pulse aborts everything from any state.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : bcd_count_ctrl_if.slave (commands, counter value, all outputs)
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bcd_count_ctrl #(
    parameter int N          = 3,
    parameter int PRESCALE   = 10,
    parameter int GATE_TICKS = 0
) (
    input  logic             clk,
    input  logic             rst,
    bcd_count_ctrl_if.slave  bus
);

    localparam int               W         = 4 * N;
    localparam int               PC_W      = $clog2(PRESCALE);
    localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PRESCALE - 1);
    localparam logic [W-1:0]     ALL_NINES = {N{4'h9}};
    localparam logic [31:0]      GATE_LAST = 32'(GATE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     tick_q, tick_d;
    logic            cnt_en_q, cnt_en_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            running_q, running_d;
    logic [W-1:0]    bcd_latched_q, bcd_latched_d;

    logic            pc_wrap;
    logic            gate_done;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        pc_d          = pc_q;
        tick_d        = tick_q;
        cnt_en_d      = 1'b0;
        cnt_clr_d     = 1'b0;
        valid_d       = valid_q;
        overflow_d    = overflow_q;
        bcd_latched_d = bcd_latched_q;
        running_d     = 1'b0;

        pc_wrap   = (pc_q == PC_LAST);
        // cnt_en_q is the enable the counter is consuming this cycle, so tick_q
        // still counts the enables before it.
        gate_done = (GATE_TICKS > 0) && cnt_en_q && (tick_q == GATE_LAST);

        if (bus.clear) begin
            state_d       = S_IDLE;
            cnt_clr_d     = 1'b1;
            valid_d       = 1'b0;
            overflow_d    = 1'b0;
            bcd_latched_d = '0;
            pc_d          = '0;
            tick_d        = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // Account for the enable being consumed now, even on the
                    // cycle that stops the measurement.
                    if (cnt_en_q) begin
                        if (tick_q != '1) tick_d = tick_q + 32'd1;
                        if (bus.bcd_in == ALL_NINES) overflow_d = 1'b1;
                    end
                    pc_d = pc_wrap ? '0 : pc_q + PC_W'(1);
                    if (bus.stop || gate_done) begin
                        state_d = S_LATCH;
                    end else if (pc_wrap) begin
                        cnt_en_d = 1'b1;
                    end
                end
                S_LATCH: begin
                    // bcd_in already includes the final enable here.
                    bcd_latched_d = bus.bcd_in;
                    valid_d       = 1'b1;
                    state_d       = S_HOLD;
                end
                S_HOLD: begin
                    if (bus.start) state_d = S_CLEAR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Entering CLEAR: the registered outputs already show the cleared
            // measurement during the CLEAR cycle itself.
            if (state_d == S_CLEAR) begin
                cnt_clr_d  = 1'b1;
                valid_d    = 1'b0;
                overflow_d = 1'b0;
                pc_d       = '0;
                tick_d     = '0;
            end
        end

        running_d = (state_d == S_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            tick_q        <= '0;
            cnt_en_q      <= 1'b0;
            cnt_clr_q     <= 1'b0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            running_q     <= 1'b0;
            bcd_latched_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tick_q        <= tick_d;
            cnt_en_q      <= cnt_en_d;
            cnt_clr_q     <= cnt_clr_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
            running_q     <= running_d;
            bcd_latched_q <= bcd_latched_d;
        end
    end

    assign bus.cnt_en      = cnt_en_q;
    assign bus.cnt_clr     = cnt_clr_q;
    assign bus.valid       = valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.running     = running_q;
    assign bus.bcd_latched = bcd_latched_q;

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Measurement-sequencing controller for the N-digit BCD counter: it generates the counter's enable ticks from a prescaler, clears it, and stops it on command or after a programmed gate length.
- It latches the final BCD value and flags decimal overflow.
- It sits between debounced front-panel pulses (start/stop/clear) and the BCD counter, and feeds the latched value to the 7-segment display path.

Parameters:
- N, 3, number of BCD digits. Counter width is 4*N.
- PRESCALE, 10, clock cycles per count tick. Legal values are 2 and above.
- GATE_TICKS, 0, ticks per measurement before auto-stop. 0 means free-run until stop.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse: begin a new measurement.
- stop  input  1  single-cycle pulse: end the measurement.
- clear  input  1  single-cycle pulse: abort and clear everything.
- bcd_in  input  4*N  live counter value (BCD, digit 0 in bits [3:0]).
- cnt_en  output  1  registered count enable to the counter.
- cnt_clr  output  1  registered synchronous clear to the counter (active-high).
- bcd_latched  output  4*N  value captured at the end of a measurement.
- valid  output  1  bcd_latched holds a completed measurement.
- overflow  output  1  sticky flag: counter wrapped past all-nines during this measurement.
- running  output  1  high while in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. cnt_en, cnt_clr, valid, overflow and running are 0. bcd_latched=0. Prescaler and tick counter are 0.
- States: IDLE, CLEAR, RUN, LATCH, HOLD. All outputs are registered.
- Input priority within one cycle: clear > stop > start.
- clear in any state:
  - next state is IDLE.
  - cnt_clr=1 for exactly one cycle.
  - valid=0, overflow=0, bcd_latched=0, cnt_en=0.
- IDLE:
  - start moves to CLEAR.
  - stop is ignored.
- CLEAR (exactly 1 cycle):
  - cnt_clr=1.
  - Prescaler, tick counter and overflow reset to 0.
  - valid=0.
  - Next state is RUN.
- RUN:
  - running=1.
  - Prescaler pc counts 0..PRESCALE-1 and wraps.
  - On the edge where pc wraps and no stop/clear is present, cnt_en=1 for the following cycle only.
  - First cnt_en comes in RUN cycle PRESCALE+1. After that, one every PRESCALE cycles.
  - The tick counter increments on every cycle with cnt_en=1.
- Overflow: any cycle with cnt_en=1 and bcd_in equal to all nines (0x999 for N=3) sets overflow. The counter itself wraps to 0; overflow stays set until CLEAR or clear.
- Stop in RUN:
  - Next state is LATCH.
  - A cnt_en already high in that cycle still counts.
  - No new cnt_en is generated on that edge.
- Auto-stop: when GATE_TICKS>0, the cycle with cnt_en=1 and tick counter == GATE_TICKS-1 moves to LATCH. Exactly GATE_TICKS enables are issued.
- start while in RUN is ignored.
- LATCH (exactly 1 cycle):
  - cnt_en=0, running=0.
  - bcd_latched <= bcd_in at the end of the cycle. bcd_in already reflects the last enable.
  - valid=1 from the next cycle.
  - Next state is HOLD.
- HOLD:
  - Outputs are frozen. cnt_en is never asserted.
  - start moves to CLEAR, which drops valid; bcd_latched keeps its old value until the next LATCH.
  - stop is ignored.
- Tick counter is 32 bits and saturates in free-run mode. Saturation does not affect counting.
- Reset asserted mid-RUN forces the reset values immediately. After release the block is in IDLE and issues no cnt_en until a start.

Test Plan:
- N=3, PRESCALE=4, GATE_TICKS=25, start pulse:
  - cnt_clr high 1 cycle.
  - 25 cnt_en pulses spaced 4 cycles apart.
  - bcd_latched=0x025, valid=1, overflow=0, running=0.
- GATE_TICKS=1005: bcd_latched=0x005 and overflow=1. Then a clear pulse gives valid=0, overflow=0, bcd_latched=0x000.
- GATE_TICKS=0, start, stop issued 50 cycles after the first cnt_en:
  - bcd_latched = count of issued enables (0x013 with PRESCALE=4 incl. edge rule).
  - No cnt_en after stop.
- Simultaneous clear+stop in RUN: state goes to IDLE, cnt_clr pulses, valid stays 0, no LATCH.
- HOLD with valid=1, then start: valid drops in CLEAR and the new measurement completes. A start during RUN has no effect on the count.
- rst driven low mid-RUN for 3 cycles, then released: all outputs read 0 asynchronously, and no cnt_en appears for 100 cycles afterwards.
